// File: rtl/isa_pkg.sv
// Shared ISA definitions for the 8-bit core: instruction format classes,
// opcode encodings, sequencer state encoding and a writeback-class helper.
package isa_pkg;

    // Instruction format classes used by the sequencer to pick an action.
    typedef enum logic [1:0] {
        FMT_MEM = 2'd0,   // data-memory access (LB, LHB, STR)
        FMT_ALU = 2'd1,   // register-to-register / immediate ALU work
        FMT_CTL = 2'd2,   // jumps and conditional branches
        FMT_SYS = 2'd3    // HALT-class instructions
    } fmt_e;

    // Opcode encodings as produced by the decoder.
    localparam logic [3:0] OP_LB   = 4'd0;
    localparam logic [3:0] OP_LHB  = 4'd1;
    localparam logic [3:0] OP_STR  = 4'd2;
    localparam logic [3:0] OP_LIM  = 4'd3;
    localparam logic [3:0] OP_MVB  = 4'd4;
    localparam logic [3:0] OP_MVF  = 4'd5;
    localparam logic [3:0] OP_ADD  = 4'd6;
    localparam logic [3:0] OP_SUB  = 4'd7;
    localparam logic [3:0] OP_SFT  = 4'd8;
    localparam logic [3:0] OP_INC  = 4'd9;
    localparam logic [3:0] OP_JMP  = 4'd10;
    localparam logic [3:0] OP_BNE  = 4'd11;
    localparam logic [3:0] OP_BEQ  = 4'd12;
    localparam logic [3:0] OP_BLT  = 4'd13;
    localparam logic [3:0] OP_HALT = 4'd14;
    localparam logic [3:0] OP_TBA  = 4'd15;

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_MEM   = 3'd3,
        ST_HALT  = 3'd4
    } seq_state_e;

    // Map an opcode onto its format class.
    function automatic fmt_e op_format(input logic [3:0] op);
        fmt_e f;
        case (op)
            OP_LB, OP_LHB, OP_STR:                    f = FMT_MEM;
            OP_LIM, OP_MVB, OP_MVF, OP_ADD,
            OP_SUB, OP_SFT, OP_INC:                   f = FMT_ALU;
            OP_JMP, OP_BNE, OP_BEQ, OP_BLT:           f = FMT_CTL;
            default:                                  f = FMT_SYS;
        endcase
        return f;
    endfunction

    // True for instructions that write a result back into the register file.
    function automatic logic op_writes_reg(input logic [3:0] op);
        logic w;
        case (op)
            OP_LB, OP_LHB, OP_LIM, OP_MVB, OP_MVF,
            OP_ADD, OP_SUB, OP_SFT, OP_INC:           w = 1'b1;
            default:                                  w = 1'b0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/pc_sequencer_branch_resolve.sv
// Branch decision: says whether a control-flow opcode redirects the PC,
// given the ALU compare flags. JMP is always taken; non-control opcodes never.
module branch_resolve
    import isa_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic       eq_flag,
    input  logic       lt_flag,
    output logic       taken
);

    // Evaluate the branch condition for the current opcode.
    always_comb begin
        taken = 1'b0;
        case (opcode)
            OP_JMP:  taken = 1'b1;
            OP_BNE:  taken = ~eq_flag;
            OP_BEQ:  taken = eq_flag;
            OP_BLT:  taken = lt_flag;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and instruction sequencer for the 8-bit ISA core.
// Steps each instruction through FETCH (decoder settle) and EXEC, detours
// through MEM for loads/stores until the memory acknowledges, and parks in
// HALT until a new start pulse. Strobes are combinational; pc, halted, busy
// and the retire counter are registered.
module pc_sequencer
    import isa_pkg::*;
#(
    parameter int unsigned     PC_W     = 16,
    parameter logic [PC_W-1:0] START_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [3:0]      opcode,
    input  logic [PC_W-1:0] branch_target,
    input  logic            eq_flag,
    input  logic            lt_flag,
    input  logic            mem_ack,
    output logic [PC_W-1:0] pc,
    output logic            alu_en,
    output logic            reg_we,
    output logic            mem_req,
    output logic            mem_we,
    output logic            retire,
    output logic            busy,
    output logic            halted,
    output logic [15:0]     instr_count
);

    seq_state_e      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            halted_q, halted_d;
    logic            busy_q, busy_d;
    logic [15:0]     instr_count_q, instr_count_d;
    logic [PC_W-1:0] pc_inc;
    logic            br_taken;

    // Sequential increment wraps naturally at 2^PC_W.
    assign pc_inc = pc_q + PC_W'(1);

    branch_resolve u_branch_resolve (
        .opcode  (opcode),
        .eq_flag (eq_flag),
        .lt_flag (lt_flag),
        .taken   (br_taken)
    );

    // Next-state, next-pc and per-cycle strobe generation.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        alu_en  = 1'b0;
        reg_we  = 1'b0;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        retire  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // Give the ROM/decoder a cycle to settle on the new pc.
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                alu_en = 1'b1;
                case (op_format(opcode))
                    FMT_ALU: begin
                        reg_we  = op_writes_reg(opcode);
                        retire  = 1'b1;
                        pc_d    = pc_inc;
                        state_d = ST_FETCH;
                    end
                    FMT_CTL: begin
                        retire  = 1'b1;
                        pc_d    = br_taken ? branch_target : pc_inc;
                        state_d = ST_FETCH;
                    end
                    FMT_MEM: begin
                        // pc is held through MEM so the opcode stays valid.
                        state_d = ST_MEM;
                    end
                    default: begin
                        retire  = 1'b1;
                        state_d = ST_HALT;
                    end
                endcase
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = (opcode == OP_STR);
                if (mem_ack) begin
                    retire  = 1'b1;
                    reg_we  = op_writes_reg(opcode);
                    pc_d    = pc_inc;
                    state_d = ST_FETCH;
                end
            end
            ST_HALT: begin
                if (start) begin
                    pc_d    = START_PC;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered status flags and the saturating retire counter.
    always_comb begin
        halted_d      = (state_d == ST_HALT);
        busy_d        = (state_d == ST_FETCH) || (state_d == ST_EXEC) ||
                        (state_d == ST_MEM);
        instr_count_d = instr_count_q;
        if (retire && (instr_count_q != 16'hFFFF)) begin
            instr_count_d = instr_count_q + 16'd1;
        end
    end

    // State, pc and status registers; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= START_PC;
            halted_q      <= 1'b0;
            busy_q        <= 1'b0;
            instr_count_q <= 16'h0000;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            halted_q      <= halted_d;
            busy_q        <= busy_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign pc          = pc_q;
    assign halted      = halted_q;
    assign busy        = busy_q;
    assign instr_count = instr_count_q;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter and instruction-sequencing controller for the 8-bit ISA core. It drives the PC into the instruction ROM/decoder and consumes the decoded opcode plus ALU compare flags. It issues per-instruction execute, register-writeback and memory-request strobes, resolves jumps and branches, and holds the core after HALT. It sits between the instruction ROM/decoder, register file, ALU and data memory.

Parameters:
PC_W, 16, program counter width in bits
START_PC, 0, PC value loaded at reset and on restart

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst_n  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse that launches execution from IDLE or HALT
opcode  in  4  decoded opcode for the instruction at pc
branch_target  in  PC_W  absolute jump/branch target, read from the register file
eq_flag  in  1  ALU compare result: reg1 == reg2
lt_flag  in  1  ALU compare result: reg1 < reg2 (unsigned)
mem_ack  in  1  data memory completion for the current request
pc  out  PC_W  current program counter (registered)
alu_en  out  1  execute strobe for the ALU
reg_we  out  1  register-file write enable
mem_req  out  1  data memory request
mem_we  out  1  memory write qualifier; 1 = store
retire  out  1  one-cycle pulse when an instruction completes
busy  out  1  high in FETCH, EXEC and MEM
halted  out  1  high in HALT (registered)
instr_count  out  16  retired-instruction counter, saturating

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - state = IDLE, pc = START_PC, instr_count = 0, halted = 0.
  - All strobes (alu_en, reg_we, mem_req, mem_we, retire) read 0.
  - Reset asserted mid-instruction aborts the instruction immediately: no retire, no write.
- State machine: IDLE, FETCH, EXEC, MEM, HALT.
- IDLE:
  - Outputs idle.
  - start = 1 -> FETCH.
- FETCH:
  - One settle cycle for the combinational ROM/decoder.
  - Always -> EXEC.
- EXEC: alu_en = 1. Action depends on opcode.
  - LIM, MVB, MVF, ADD, SUB, SFT, INC: reg_we = 1, retire = 1, pc <= pc+1, -> FETCH.
  - JMP: pc <= branch_target, retire = 1, -> FETCH.
  - BNE: pc <= branch_target if !eq_flag, else pc+1.
  - BEQ: pc <= branch_target if eq_flag, else pc+1.
  - BLT: pc <= branch_target if lt_flag, else pc+1.
  - All branches: retire = 1, -> FETCH.
  - LB, LHB, STR: -> MEM; pc unchanged; no retire.
  - HALT, TBA: retire = 1, pc unchanged, -> HALT.
- MEM:
  - mem_req = 1 continuously; mem_we = 1 only for STR. pc is held so opcode stays stable.
  - mem_ack = 0: stay in MEM with no timeout.
  - mem_ack = 1:
    - retire = 1, pc <= pc+1, -> FETCH.
    - reg_we = 1 in the same cycle for LB/LHB only, never for STR.
- HALT:
  - halted = 1, busy = 0; pc frozen.
  - start = 1 -> pc <= START_PC, instr_count kept, -> FETCH.
- Output timing:
  - Strobes are combinational from state, opcode and mem_ack.
  - pc, halted, busy and instr_count are registered.
- Latency:
  - Non-memory instruction: 2 cycles (FETCH + EXEC).
  - Memory instruction: 3 + N cycles, where N is the number of wait cycles before mem_ack.
- Arithmetic and boundaries:
  - pc+1 wraps from 2^PC_W-1 to 0.
  - A branch to its own address is legal (tight loop).
  - instr_count increments on retire and saturates at 0xFFFF.
  - start while busy is ignored.
  - mem_ack outside MEM is ignored.
  - Simultaneous start and mem_ack in MEM: mem_ack is serviced, start is ignored.

Decomposition:
- Shared package isa_pkg holds:
  - the 2-bit format codes and the 4-bit opcode constants (LB=0 through TBA=15);
  - the sequencer state enum;
  - a writeback-class helper function.
- One combinational sub-module, branch_resolve: inputs opcode, eq_flag, lt_flag; output taken (1 for JMP).

Test Plan:
1. Reset, then start, with ROM words 0..4 = lim, inc, lim, sft, mvf -> pc steps 0,1,2,3,4 every 2 cycles; reg_we 5 times; instr_count = 5.
2. BEQ at pc=6 with branch_target=0x20 -> eq_flag=1 gives pc=0x20; eq_flag=0 gives pc=7. BNE and BLT checked with the complementary flags.
3. LB at pc=3 with mem_ack after 4 wait cycles -> mem_req high for 5 cycles, mem_we=0, reg_we=1 only in the ack cycle, then pc=4. STR repeats with mem_we=1 and reg_we never set.
4. HALT at pc=9 -> halted=1, pc stays 9 for 20 cycles; start -> pc=START_PC, busy=1, instr_count preserved.
5. PC_W=4, pc=15 executing ADD -> pc wraps to 0. instr_count preloaded to 0xFFFF by running instructions stays at 0xFFFF.
6. rst_n pulled low during MEM -> pc=START_PC, mem_req=0, no retire. After release, the core waits in IDLE until start.
